// File: rtl/decode_stall_scheduler_pkg.sv
// Shared types and constants for the decode stall scheduler.
//   sched_state_e : scheduler FSM states
//   sb_entry_t    : one in-flight destination record {valid, rd}
//   STALL_*       : stall cycles owed when a source matches EX / MEM
package decode_stall_scheduler_pkg;

  localparam int REG_W    = 5;  // register index width carried in scoreboard entries
  localparam int SB_DEPTH = 3;  // EX, MEM, WB

  localparam logic [1:0] STALL_EX_CYCLES  = 2'd2;
  localparam logic [1:0] STALL_MEM_CYCLES = 2'd1;

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  // Stall cycles owed to a producer sitting in scoreboard slot 'stage'.
  // WB owes nothing: the register file writes before it reads.
  function automatic logic [1:0] stage_cycles(input int stage);
    case (stage)
      0:       return STALL_EX_CYCLES;
      1:       return STALL_MEM_CYCLES;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decode_stall_scheduler_if.sv
// Decode-stage <-> scheduler signal bundle.
//   master : decode side, drives id*/branchTaken, observes enables/status
//   slave  : scheduler, observes decode, drives enables/status
// STALL_STATS_EN adds the statStallCycles / statFlushes counters.
interface decode_stall_scheduler_if #(
  parameter int REGISTERWIDTH = decode_stall_scheduler_pkg::REG_W
`ifdef STALL_STATS_EN
  , parameter int STAT_WIDTH = 32
`endif
);
  logic                     idValid;
  logic [REGISTERWIDTH-1:0] idRs1;
  logic [REGISTERWIDTH-1:0] idRs2;
  logic                     idUsesRs2;
  logic [REGISTERWIDTH-1:0] idRd;
  logic                     idRegWrite;
  logic                     idHalt;
  logic                     branchTaken;

  logic                     pcWrite;
  logic                     ifIdWrite;
  logic                     ifIdFlush;
  logic                     idExBubble;
  logic                     hazardDetected;
  logic [1:0]               stallCount;
  logic                     haltSignal;
  logic                     pipelineEmpty;

`ifdef STALL_STATS_EN
  logic [STAT_WIDTH-1:0]    statStallCycles;
  logic [STAT_WIDTH-1:0]    statFlushes;

  modport master (
    output idValid, idRs1, idRs2, idUsesRs2, idRd, idRegWrite, idHalt, branchTaken,
    input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, hazardDetected, stallCount,
           haltSignal, pipelineEmpty, statStallCycles, statFlushes
  );
  modport slave (
    input  idValid, idRs1, idRs2, idUsesRs2, idRd, idRegWrite, idHalt, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, hazardDetected, stallCount,
           haltSignal, pipelineEmpty, statStallCycles, statFlushes
  );
`else
  modport master (
    output idValid, idRs1, idRs2, idUsesRs2, idRd, idRegWrite, idHalt, branchTaken,
    input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, hazardDetected, stallCount,
           haltSignal, pipelineEmpty
  );
  modport slave (
    input  idValid, idRs1, idRs2, idUsesRs2, idRd, idRegWrite, idHalt, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, hazardDetected, stallCount,
           haltSignal, pipelineEmpty
  );
`endif

endinterface

// File: rtl/decode_stall_scheduler_dest_scoreboard.sv
// In-flight destination scoreboard: 3-entry shift register (EX, MEM, WB)
// plus the RAW match that reports how many stall cycles decode owes.
//   clk, reset    : clock, async active-high reset (clears all entries)
//   shift_en_i    : advance one stage (held while halted)
//   new_entry_i   : record entering EX
//   src_valid_i   : decode slot is a real instruction
//   rs1_i, rs2_i  : decode sources; uses_rs2_i qualifies rs2
//   required_o    : stall cycles needed (max over sources)
//   empty_o       : no valid entry in flight
module decode_stall_scheduler_dest_scoreboard
  import decode_stall_scheduler_pkg::*;
#(
  parameter int REGISTERWIDTH = REG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     shift_en_i,
  input  sb_entry_t                new_entry_i,
  input  logic                     src_valid_i,
  input  logic [REGISTERWIDTH-1:0] rs1_i,
  input  logic [REGISTERWIDTH-1:0] rs2_i,
  input  logic                     uses_rs2_i,
  output logic [1:0]               required_o,
  output logic                     empty_o
);

  // sb_q[0] = EX, sb_q[1] = MEM, sb_q[2] = WB
  sb_entry_t [SB_DEPTH-1:0] sb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           sb_q <= '0;
    else if (shift_en_i) sb_q <= {sb_q[SB_DEPTH-2:0], new_entry_i};
  end

  logic [1:0] need1, need2;

  // Walk oldest to youngest so the youngest (most expensive) match wins.
  always_comb begin
    need1 = '0;
    need2 = '0;
    for (int i = SB_DEPTH-1; i >= 0; i--) begin
      if (sb_q[i].valid && rs1_i != '0 && sb_q[i].rd == rs1_i)
        need1 = stage_cycles(i);
      if (uses_rs2_i && sb_q[i].valid && rs2_i != '0 && sb_q[i].rd == rs2_i)
        need2 = stage_cycles(i);
    end
    required_o = src_valid_i ? max2(need1, need2) : 2'd0;
  end

  always_comb begin
    empty_o = 1'b1;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_q[i].valid) empty_o = 1'b0;
  end

endmodule

// File: rtl/decode_stall_scheduler.sv
// Decode stall scheduler for a no-forwarding pipeline. Stalls IF/ID on RAW
// hazards against in-flight destinations, flushes wrong-path slots on a
// taken branch, and drains then freezes the pipe on HALT.
//   clk, reset : clock, async active-high reset
//   io (slave) : decode inputs, PC/IF-ID/ID-EX controls, status
// Optional build macro STALL_STATS_EN adds saturating stall-cycle and
// branch-flush counters.
module decode_stall_scheduler
  import decode_stall_scheduler_pkg::*;
#(
  parameter int REGISTERWIDTH = REG_W,
  parameter int DRAIN_DEPTH   = 3
`ifdef STALL_STATS_EN
  , parameter int STAT_WIDTH  = 32
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  decode_stall_scheduler_if.slave  io
);

  localparam logic [1:0] DRAIN_CNT = 2'(DRAIN_DEPTH - 1);

  sched_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   required;
  logic         hazard, halt_req, sb_empty;
  sb_entry_t    new_entry;

  // A bubbled slot never enters the scoreboard; r0 writes are never tracked.
  always_comb begin
    new_entry.valid = io.idValid & io.idRegWrite & (io.idRd != '0) & ~io.idExBubble;
    new_entry.rd    = io.idRd;
  end

  decode_stall_scheduler_dest_scoreboard #(.REGISTERWIDTH(REGISTERWIDTH)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .shift_en_i  (state_q != HALTED),
    .new_entry_i (new_entry),
    .src_valid_i (io.idValid),
    .rs1_i       (io.idRs1),
    .rs2_i       (io.idRs2),
    .uses_rs2_i  (io.idUsesRs2),
    .required_o  (required),
    .empty_o     (sb_empty)
  );

  assign hazard   = (required != 2'd0);
  assign halt_req = io.idValid & io.idHalt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The RUN cycle that detects a hazard is itself the first stall cycle, so
  // a one-cycle hazard stays in RUN and decode is re-evaluated next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (io.branchTaken) begin
          cnt_d = '0;
        end else if (hazard) begin
          if (required > 2'd1) begin
            state_d = STALL;
            cnt_d   = required - 2'd1;
          end
        end else if (halt_req) begin
          if (DRAIN_DEPTH > 1) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_CNT;
          end else begin
            state_d = HALTED;
          end
        end
      end
      STALL, DRAIN: begin
        if (io.branchTaken) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q <= 2'd1) begin
          state_d = (state_q == STALL) ? RUN : HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: ;  // HALTED: only reset leaves
    endcase
  end

  // Reset overrides combinationally so the pipe is frozen while it is held.
  always_comb begin
    io.pcWrite        = 1'b0;
    io.ifIdWrite      = 1'b0;
    io.ifIdFlush      = 1'b0;
    io.idExBubble     = 1'b1;
    io.hazardDetected = 1'b0;
    io.stallCount     = 2'd0;
    io.haltSignal     = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (io.branchTaken) begin
            io.ifIdFlush = 1'b1;
            io.pcWrite   = 1'b1;
          end else if (hazard) begin
            io.hazardDetected = 1'b1;
          end else if (!halt_req) begin
            io.pcWrite    = 1'b1;
            io.ifIdWrite  = 1'b1;
            io.idExBubble = 1'b0;
          end
        end
        STALL: begin
          if (io.branchTaken) begin
            io.ifIdFlush = 1'b1;
            io.pcWrite   = 1'b1;
          end else begin
            io.hazardDetected = 1'b1;
            io.stallCount     = cnt_q;
          end
        end
        DRAIN: begin
          if (io.branchTaken) begin
            io.ifIdFlush = 1'b1;
            io.pcWrite   = 1'b1;
          end
        end
        default: io.haltSignal = 1'b1;
      endcase
    end
  end

  assign io.pipelineEmpty = sb_empty;

`ifdef STALL_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cyc_q, flush_q;
  logic                  branch_act;

  assign branch_act = io.branchTaken & (state_q != HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cyc_q <= '0;
      flush_q     <= '0;
    end else begin
      if (io.hazardDetected && stall_cyc_q != '1) stall_cyc_q <= stall_cyc_q + STAT_WIDTH'(1);
      if (branch_act && flush_q != '1)            flush_q     <= flush_q + STAT_WIDTH'(1);
    end
  end

  assign io.statStallCycles = stall_cyc_q;
  assign io.statFlushes     = flush_q;
`endif

endmodule
